// File: rtl/pulse_detect.sv
// Edge-to-pulse front end: synchronises and glitch-filters sig_in, turns the selected
// edge of the clean level into a one-cycle pulse with hold-off, and keeps saturating status counts.
module pulse_detect #(
  parameter int    SYNC_STAGES = 2,
  parameter int    FILTER_LEN  = 4,
  parameter string EDGE        = "RISE",
  parameter logic  INIT_LEVEL  = 1'b0,
  parameter int    HOLDOFF     = 16,
  parameter int    CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 en,
  input  logic                 clr_cnt,
  output logic                 pulse_out,
  output logic                 busy,
  output logic                 level,
  output logic [CNT_WIDTH-1:0] pulse_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam logic RISE_EN = (EDGE == "RISE") || (EDGE == "BOTH");
  localparam logic FALL_EN = (EDGE == "FALL") || (EDGE == "BOTH");
  localparam logic HOLD_EN = (HOLDOFF > 0);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [FW-1:0]        FLT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0]        FLT_ONE   = FW'(1);
  localparam logic [FW-1:0]        FLT_ZERO  = {FW{1'b0}};
  localparam logic [TW-1:0]        TMR_LOAD  = TW'(HOLDOFF);
  localparam logic [TW-1:0]        TMR_ONE   = TW'(1);
  localparam logic [TW-1:0]        TMR_ZERO  = {TW{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // A clear wins over the increment but still records an event landing in the same cycle.
  function automatic logic [CNT_WIDTH-1:0] sat_count(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 clr,
    input logic                 hit
  );
    logic [CNT_WIDTH-1:0] nxt;
    if (clr) begin
      nxt = hit ? CNT_ONE : CNT_ZERO;
    end else if (hit && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic [FW-1:0]          flt_cnt_r;
  logic                   level_r;
  logic                   level_d_r;
  logic [0:0]             state_r;
  logic [TW-1:0]          timer_r;
  logic                   pulse_r;
  logic                   busy_r;
  logic [CNT_WIDTH-1:0]   pulse_cnt_r;
  logic [CNT_WIDTH-1:0]   miss_cnt_r;

  logic s_s;
  logic edge_s;
  logic accept_s;
  logic miss_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain and glitch filter on the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= {SYNC_STAGES{INIT_LEVEL}};
      flt_cnt_r <= FLT_ZERO;
      level_r   <= INIT_LEVEL;
      level_d_r <= INIT_LEVEL;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], sig_in};
      level_d_r <= level_r;
      if (s_s != level_r) begin
        if (flt_cnt_r == FLT_LAST) begin
          level_r   <= s_s;
          flt_cnt_r <= FLT_ZERO;
        end else begin
          flt_cnt_r <= flt_cnt_r + FLT_ONE;
        end
      end else begin
        flt_cnt_r <= FLT_ZERO;
      end
    end
  end

  // Qualify the level change and decide accept versus miss.
  always_comb begin
    edge_s   = (RISE_EN & level_r & ~level_d_r) | (FALL_EN & ~level_r & level_d_r);
    accept_s = 1'b0;
    miss_s   = 1'b0;
    if (edge_s && en) begin
      if (state_r == ST_IDLE) begin
        accept_s = 1'b1;
      end else begin
        miss_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      miss_s   = 1'b0;
    end
  end

  // Hold-off FSM; HOLD spans the pulse cycle plus HOLDOFF busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pulse_r <= accept_s;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (accept_s && HOLD_EN) begin
            state_r <= ST_HOLD;
            timer_r <= TMR_LOAD;
          end else begin
            state_r <= ST_IDLE;
            timer_r <= TMR_ZERO;
          end
        end
        ST_HOLD: begin
          if (timer_r == TMR_ZERO) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= TMR_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_r <= CNT_ZERO;
      miss_cnt_r  <= CNT_ZERO;
    end else begin
      pulse_cnt_r <= sat_count(pulse_cnt_r, clr_cnt, accept_s);
      miss_cnt_r  <= sat_count(miss_cnt_r, clr_cnt, miss_s);
    end
  end

  assign pulse_out = pulse_r;
  assign busy      = busy_r;
  assign level     = level_r;
  assign pulse_cnt = pulse_cnt_r;
  assign miss_cnt  = miss_cnt_r;

endmodule

// File: tb/tb_pulse_detect.sv
// Self-checking bench: four differently configured pulse_detect instances share one stimulus
// stream and are compared every cycle against a sample-history model of the behaviour.
module tb_pulse_detect;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic en = 1'b1;
  logic clr_cnt = 1'b0;

  logic [NC-1:0] pulse_o, busy_o, level_o;
  logic [15:0]   pc0, mc0, pc1, mc1, pc3, mc3;
  logic [1:0]    pc2, mc2;

  always #5 clk = ~clk;

  pulse_detect u0 (.clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clr_cnt(clr_cnt),
                   .pulse_out(pulse_o[0]), .busy(busy_o[0]), .level(level_o[0]),
                   .pulse_cnt(pc0), .miss_cnt(mc0));

  pulse_detect #(.EDGE("BOTH"), .HOLDOFF(0)) u1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clr_cnt(clr_cnt),
    .pulse_out(pulse_o[1]), .busy(busy_o[1]), .level(level_o[1]),
    .pulse_cnt(pc1), .miss_cnt(mc1));

  pulse_detect #(.EDGE("FALL"), .HOLDOFF(3), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clr_cnt(clr_cnt),
    .pulse_out(pulse_o[2]), .busy(busy_o[2]), .level(level_o[2]),
    .pulse_cnt(pc2), .miss_cnt(mc2));

  pulse_detect #(.SYNC_STAGES(3), .FILTER_LEN(1), .EDGE("BOTH"), .INIT_LEVEL(1'b1), .HOLDOFF(5)) u3 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en), .clr_cnt(clr_cnt),
    .pulse_out(pulse_o[3]), .busy(busy_o[3]), .level(level_o[3]),
    .pulse_cnt(pc3), .miss_cnt(mc3));

  // Per-instance configuration; edge code 0 = rise, 1 = fall, 2 = both.
  function automatic int c_sync(int c); return (c == 3) ? 3 : 2; endfunction
  function automatic int c_fl(int c);   return (c == 3) ? 1 : 4; endfunction
  function automatic int c_init(int c); return (c == 3) ? 1 : 0; endfunction
  function automatic int c_max(int c);  return (c == 2) ? 3 : 65535; endfunction
  function automatic int c_edge(int c);
    case (c)
      0: return 0;
      2: return 1;
      default: return 2;
    endcase
  endfunction
  function automatic int c_hold(int c);
    case (c)
      0: return 16;
      1: return 0;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  int samp [0:8191];
  int j;
  int lvl[NC], last_flip[NC], pflip[NC], last_acc[NC], have_acc[NC];
  int pcnt[NC], mcnt[NC], xp[NC], xb[NC];
  int vectors = 0;
  int fails = 0;
  int checks = 0;
  int first0 = -1;
  int busy0 = 0;
  int busy1_seen = 0;

  // Value presented by the last synchroniser flop after edge i.
  function automatic int s_after(int c, int i);
    int k;
    k = i - c_sync(c) + 1;
    if (k >= 0) return samp[k];
    return c_init(c);
  endfunction

  task automatic model_reset();
    j = 0;
    for (int c = 0; c < NC; c++) begin
      lvl[c] = c_init(c);
      last_flip[c] = -1;
      pflip[c] = 0;
      have_acc[c] = 0;
      last_acc[c] = 0;
      pcnt[c] = 0;
      mcnt[c] = 0;
      xp[c] = 0;
      xb[c] = 0;
    end
  endtask

  task automatic model_edge();
    samp[j] = int'(sig_in);
    for (int c = 0; c < NC; c++) begin
      int qual, ok, blocked, acc, mis, d;
      qual = pflip[c] && (c_edge(c) == 2 || (c_edge(c) == 0 && lvl[c] == 1) ||
                          (c_edge(c) == 1 && lvl[c] == 0));
      ok = (j - c_fl(c) >= last_flip[c]);
      for (int k = j - c_fl(c); k < j; k++)
        if (s_after(c, k) == lvl[c]) ok = 0;
      if (ok != 0) begin
        lvl[c] = 1 - lvl[c];
        last_flip[c] = j;
      end
      pflip[c] = ok;
      blocked = (c_hold(c) > 0) && (have_acc[c] != 0) && (j - last_acc[c] <= c_hold(c) + 1);
      acc = (qual != 0) && en && (blocked == 0);
      mis = (qual != 0) && en && (blocked != 0);
      if (acc != 0) begin
        have_acc[c] = 1;
        last_acc[c] = j;
      end
      d = j - last_acc[c];
      xb[c] = (have_acc[c] != 0) && (c_hold(c) > 0) && (d >= 1) && (d <= c_hold(c));
      xp[c] = acc;
      if (clr_cnt) pcnt[c] = acc;
      else if (acc != 0 && pcnt[c] < c_max(c)) pcnt[c] = pcnt[c] + 1;
      if (clr_cnt) mcnt[c] = mis;
      else if (mis != 0 && mcnt[c] < c_max(c)) mcnt[c] = mcnt[c] + 1;
    end
    j = j + 1;
  endtask

  function automatic int act_pc(int c);
    case (c)
      0: return int'(pc0);
      1: return int'(pc1);
      2: return int'(pc2);
      default: return int'(pc3);
    endcase
  endfunction

  function automatic int act_mc(int c);
    case (c)
      0: return int'(mc0);
      1: return int'(mc1);
      2: return int'(mc2);
      default: return int'(mc3);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, j - 1, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("u%0d.pulse_out", c), int'(pulse_o[c]), xp[c]);
      chk($sformatf("u%0d.busy", c), int'(busy_o[c]), xb[c]);
      chk($sformatf("u%0d.level", c), int'(level_o[c]), lvl[c]);
      chk($sformatf("u%0d.pulse_cnt", c), act_pc(c), pcnt[c]);
      chk($sformatf("u%0d.miss_cnt", c), act_mc(c), mcnt[c]);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic c);
    sig_in = s;
    en = e;
    clr_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    vectors++;
    if (pulse_o[0] && first0 < 0) first0 = j - 1;
    busy0 = busy0 + int'(busy_o[0]);
    if (busy_o[1]) busy1_seen = 1;
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #2;
    rst_n = 1'b1;
    first0 = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #2;
    rst_n = 1'b1;

    // Clean step sampled at edge 0.
    repeat (40) step(1'b1, 1'b1, 1'b0);
    chk("u0.first_pulse_edge", first0, 6);
    chk("u0.busy_cycles", busy0, 16);
    chk("u0.pulse_cnt_after_step", int'(pc0), 1);

    // Short glitch is rejected.
    repeat (20) step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    chk("u0.pulse_cnt_after_glitch", int'(pc0), 1);
    chk("u0.level_after_glitch", int'(level_o[0]), 0);

    // 4-cycle pulse accepted, next rise lands in hold-off, third rise just after it.
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0);
    chk("u0.pulse_cnt_before_clr", int'(pc0), 2);
    chk("u0.miss_cnt_holdoff", int'(mc0), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("u0.pulse_with_clr", int'(pulse_o[0]), 1);
    chk("u0.pulse_cnt_clr_same_cycle", int'(pc0), 1);
    chk("u0.miss_cnt_cleared", int'(mc0), 0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);

    // Ten toggles every 8 cycles.
    step(1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 10; t++)
      repeat (8) step((t % 2) == 0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0);
    chk("u1.pulse_cnt_toggles", int'(pc1), 10);
    chk("u1.busy_ever_high", busy1_seen, 0);
    chk("u2.pulse_cnt_saturated", int'(pc2), 3);

    // Reset in the middle of hold-off with sig_in held high.
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("u0.busy_before_reset", int'(busy_o[0]), 1);
    do_reset();
    repeat (20) step(1'b1, 1'b1, 1'b0);
    chk("u0.first_pulse_after_reset", first0, 6);
    chk("u3.pulse_cnt_init_high", int'(pc3), 0);

    // Randomised segments with occasional enable drops and clears.
    for (int r = 0; r < 2; r++) begin
      int left;
      left = 1200;
      while (left > 0) begin
        logic lv;
        int len;
        lv = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 12);
        for (int k = 0; k < len && left > 0; k++) begin
          step(lv, $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);
          left--;
        end
      end
      if (r == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
